// File: rtl/led_fx_pkg.sv
// Shared types and derived timing constants for the LED effect engine.
package led_fx_pkg;

  typedef enum logic [1:0] {
    FX_OFF   = 2'd0,
    FX_SPLIT = 2'd1,
    FX_FLOW  = 2'd2,
    FX_SYNC  = 2'd3
  } fx_mode_t;

  function automatic int pwm_period(input int clk_freq, input int pwm_freq);
    return clk_freq / pwm_freq;
  endfunction

  function automatic int pwm_div(input int period, input int levels);
    return period / levels;
  endfunction

  function automatic int step_clk(input int clk_freq, input int step_ms);
    return (clk_freq / 1000) * step_ms;
  endfunction

  // The duty compare only lands on exact level boundaries when the period divides evenly.
  function automatic bit period_ok(input int period, input int levels);
    return (period % levels) == 0;
  endfunction

endpackage

// File: rtl/led_fx_timebase.sv
// PWM period counter plus the base-step counter and speed divider that produce step ticks.
module led_fx_timebase #(
  parameter int PWM_PERIOD = 100000,
  parameter int STEP_CLK   = 4000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hold,
  input  logic                          restart,
  input  logic [1:0]                    speed,
  output logic [$clog2(PWM_PERIOD)-1:0] pwm_cnt,
  output logic                          period_wrap,
  output logic                          step_tick
);
  localparam int PW = $clog2(PWM_PERIOD);
  localparam int BW = $clog2(STEP_CLK);

  logic [PW-1:0] pwm_cnt_reg;
  logic [BW-1:0] base_cnt_reg;
  logic [1:0]    div_cnt_reg;
  logic          step_tick_reg;
  logic          base_tick;
  logic          div_hit;

  assign period_wrap = pwm_cnt_reg == PW'(PWM_PERIOD - 1);
  assign base_tick   = base_cnt_reg == BW'(STEP_CLK - 1);
  // >= rather than == so lowering speed mid-interval fires on the very next base tick.
  assign div_hit     = div_cnt_reg >= speed;

  always_ff @(posedge clk) begin
    if (rst || period_wrap) pwm_cnt_reg <= '0;
    else                    pwm_cnt_reg <= pwm_cnt_reg + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || hold || restart) begin
      base_cnt_reg  <= '0;
      div_cnt_reg   <= '0;
      step_tick_reg <= 1'b0;
    end else begin
      step_tick_reg <= base_tick && div_hit;
      if (base_tick) begin
        base_cnt_reg <= '0;
        div_cnt_reg  <= div_hit ? 2'd0 : div_cnt_reg + 2'd1;
      end else begin
        base_cnt_reg <= base_cnt_reg + BW'(1);
      end
    end
  end

  assign pwm_cnt   = pwm_cnt_reg;
  assign step_tick = step_tick_reg;

endmodule

// File: rtl/led_fx_engine.sv
// LED effect engine: breathe / split-breathe / bouncing flow over an N-LED bank on one PWM timebase.
module led_fx_engine import led_fx_pkg::*; #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int PWM_FREQ = 1000,
  parameter int N_LED    = 16,
  parameter int LEVELS   = 100,
  parameter int STEP_MS  = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  output logic [N_LED-1:0] led,
  output logic             step_pulse
);
  localparam int PWM_PERIOD = pwm_period(CLK_FREQ, PWM_FREQ);
  localparam int PWM_DIV    = pwm_div(PWM_PERIOD, LEVELS);
  localparam int STEP_CLK   = step_clk(CLK_FREQ, STEP_MS);
  localparam int PW         = $clog2(PWM_PERIOD);
  localparam int LW         = $clog2(LEVELS + 1);
  localparam int HW         = $clog2(N_LED);
  localparam logic [LW-1:0] LVL_MAX  = LW'(LEVELS);
  localparam logic [HW-1:0] H_LAST   = HW'(N_LED - 1);
  localparam logic          DIR_UP   = 1'b0;
  localparam logic          DIR_DOWN = 1'b1;

  if (!period_ok(PWM_PERIOD, LEVELS) || (N_LED % 2) != 0 || N_LED < 4) begin : g_param_check
    $error("led_fx_engine: PWM_PERIOD must be a multiple of LEVELS and N_LED must be even and >= 4");
  end

  fx_mode_t      mode_sel;
  logic [1:0]    mode_prev_reg;
  logic          restart;
  logic          hold;
  logic [PW-1:0] pwm_cnt;
  logic          period_wrap;
  logic          step_tick;
  logic [LW-1:0] lvl_reg, hl_reg, fl_reg;
  logic [HW-1:0] h_reg, f_reg;
  logic          dir_reg, fdir_reg;
  logic          blank_reg;

  assign mode_sel = fx_mode_t'(mode);
  assign restart  = mode != mode_prev_reg;
  assign hold     = mode_sel == FX_OFF;

  led_fx_timebase #(
    .PWM_PERIOD (PWM_PERIOD),
    .STEP_CLK   (STEP_CLK)
  ) u_timebase (
    .clk         (clk),
    .rst         (rst),
    .hold        (hold),
    .restart     (restart),
    .speed       (speed),
    .pwm_cnt     (pwm_cnt),
    .period_wrap (period_wrap),
    .step_tick   (step_tick)
  );

  always_ff @(posedge clk) begin
    mode_prev_reg <= mode;
  end

  // Blanking hides the stale shadow levels of the old mode until a fresh period starts.
  always_ff @(posedge clk) begin
    if (rst)              blank_reg <= 1'b0;
    else if (restart)     blank_reg <= 1'b1;
    else if (period_wrap) blank_reg <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || restart || hold) begin
      lvl_reg  <= '0;
      dir_reg  <= DIR_UP;
      h_reg    <= '0;
      hl_reg   <= '0;
      f_reg    <= '0;
      fl_reg   <= '0;
      fdir_reg <= DIR_UP;
    end else if (step_tick) begin
      case (mode_sel)
        FX_SPLIT, FX_SYNC: begin
          if (dir_reg == DIR_UP) begin
            if (lvl_reg == LVL_MAX) begin
              dir_reg <= DIR_DOWN;
              lvl_reg <= LVL_MAX - LW'(1);
            end else begin
              lvl_reg <= lvl_reg + LW'(1);
            end
          end else if (lvl_reg == '0) begin
            dir_reg <= DIR_UP;
            lvl_reg <= LW'(1);
          end else begin
            lvl_reg <= lvl_reg - LW'(1);
          end
        end
        FX_FLOW: begin
          if (hl_reg == LVL_MAX) begin
            f_reg  <= h_reg;
            fl_reg <= LVL_MAX;
            hl_reg <= '0;
            if (fdir_reg == DIR_UP) begin
              if (h_reg == H_LAST) begin
                h_reg    <= H_LAST - HW'(1);
                fdir_reg <= DIR_DOWN;
              end else begin
                h_reg <= h_reg + HW'(1);
              end
            end else if (h_reg == '0) begin
              h_reg    <= HW'(1);
              fdir_reg <= DIR_UP;
            end else begin
              h_reg <= h_reg - HW'(1);
            end
          end else begin
            hl_reg <= hl_reg + LW'(1);
            if (fl_reg != '0) fl_reg <= fl_reg - LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < N_LED; gi++) begin : g_led
    localparam logic [HW-1:0] IDX   = HW'(gi);
    localparam bit            LOWER = gi < N_LED / 2;

    logic [LW-1:0] level_next;
    logic [LW-1:0] shadow_reg;
    logic          led_reg;
    logic          head_hit;
    logic          fade_hit;

    assign head_hit = h_reg == IDX;
    assign fade_hit = (f_reg == IDX) && (fl_reg != '0) && (f_reg != h_reg);

    always_comb begin
      level_next = '0;
      case (mode_sel)
        FX_SPLIT: level_next = LOWER ? lvl_reg : LVL_MAX - lvl_reg;
        FX_SYNC:  level_next = lvl_reg;
        FX_FLOW: begin
          if (head_hit)      level_next = hl_reg;
          else if (fade_hit) level_next = fl_reg;
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst)              shadow_reg <= '0;
      else if (period_wrap) shadow_reg <= level_next;
    end

    always_ff @(posedge clk) begin
      if (rst) led_reg <= 1'b0;
      else     led_reg <= !(blank_reg || restart) && (int'(pwm_cnt) < int'(shadow_reg) * PWM_DIV);
    end

    assign led[gi] = led_reg;
  end

  assign step_pulse = step_tick;

endmodule

// File: tb/tb_led_fx_engine.sv
// Scoreboarded bench for led_fx_engine with a small PWM/step geometry (period 10, step 20 clk).
module tb_led_fx_engine;
  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [1:0] mode  = 2'd1;
  logic [1:0] speed = 2'd0;
  logic [7:0] led;
  logic       step_pulse;

  led_fx_engine #(
    .CLK_FREQ (1000),
    .PWM_FREQ (100),
    .N_LED    (8),
    .LEVELS   (5),
    .STEP_MS  (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .speed      (speed),
    .led        (led),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] led;
    logic       pulse;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   cyc        = 0;
  int   last_pulse = -1;
  int   skip_gap   = 0;
  int   exp_gap    = 20;
  int   n_pulses   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, want %0h", tag, $time, got, want);
    end
  endtask

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Reference model: one expected (led, step_pulse) pair per clock edge.
  initial begin : model
    int   m_pwm, m_base, m_div, m_lvl, m_h, m_hl, m_f, m_fl;
    bit   m_tick, m_blank, m_down, m_fdown, restart, idle, wrap;
    logic [1:0] m_prev;
    int   m_shadow[8];
    int   lv[8];
    exp_t e;
    forever begin
      @(posedge clk);
      e = '0;
      if (rst) begin
        m_pwm = 0; m_base = 0; m_div = 0; m_tick = 0; m_blank = 0;
        m_lvl = 0; m_down = 0; m_h = 0; m_hl = 0; m_f = 0; m_fl = 0; m_fdown = 0;
        for (int i = 0; i < 8; i++) m_shadow[i] = 0;
        m_prev = mode;
      end else begin
        restart = (mode != m_prev);
        idle    = (mode == 2'd0);
        wrap    = (m_pwm == 9);
        for (int i = 0; i < 8; i++) begin
          case (mode)
            2'd1:    lv[i] = (i < 4) ? m_lvl : 5 - m_lvl;
            2'd3:    lv[i] = m_lvl;
            2'd2:    lv[i] = (i == m_h) ? m_hl : ((i == m_f && m_fl > 0) ? m_fl : 0);
            default: lv[i] = 0;
          endcase
          e.led[i] = !(m_blank || restart) && (m_pwm < 2 * m_shadow[i]);
        end
        if (wrap) for (int i = 0; i < 8; i++) m_shadow[i] = lv[i];
        if (restart) m_blank = 1;
        else if (wrap) m_blank = 0;
        m_pwm = wrap ? 0 : m_pwm + 1;
        if (idle || restart) begin
          m_lvl = 0; m_down = 0; m_h = 0; m_hl = 0; m_f = 0; m_fl = 0; m_fdown = 0;
        end else if (m_tick) begin
          if (mode == 2'd1 || mode == 2'd3) begin
            if (!m_down) begin
              if (m_lvl == 5) begin m_down = 1; m_lvl = 4; end
              else m_lvl++;
            end else begin
              if (m_lvl == 0) begin m_down = 0; m_lvl = 1; end
              else m_lvl--;
            end
          end else if (mode == 2'd2) begin
            if (m_hl == 5) begin
              m_f = m_h; m_fl = 5; m_hl = 0;
              if (!m_fdown) begin
                if (m_h == 7) begin m_h = 6; m_fdown = 1; end
                else m_h++;
              end else begin
                if (m_h == 0) begin m_h = 1; m_fdown = 0; end
                else m_h--;
              end
            end else begin
              m_hl++;
              if (m_fl > 0) m_fl--;
            end
          end
        end
        if (idle || restart) begin
          m_base = 0; m_div = 0; m_tick = 0;
        end else begin
          m_tick = (m_base == 19) && (m_div >= int'(speed));
          if (m_base == 19) begin
            m_base = 0;
            m_div  = (m_div >= int'(speed)) ? 0 : m_div + 1;
          end else begin
            m_base++;
          end
        end
        e.pulse = m_tick;
        m_prev  = mode;
      end
      exp_q.push_back(e);
    end
  end

  initial begin : scoreboard
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("led", 32'(led), 32'(e.led));
        check_eq("step_pulse", 32'(step_pulse), 32'(e.pulse));
      end
    end
  end

  // One line per step transaction, with the spacing checked against the selected speed.
  initial begin : pulse_mon
    forever begin
      @(negedge clk);
      if (rst) begin
        last_pulse = -1;
      end else if (step_pulse) begin
        if (skip_gap > 0) skip_gap--;
        else if (last_pulse >= 0) check_eq("step gap", 32'(cyc - last_pulse), 32'(exp_gap));
        $display("step cyc=%0d gap=%0d mode=%0d speed=%0d led=%b", cyc,
                 (last_pulse >= 0) ? cyc - last_pulse : -1, mode, speed, led);
        last_pulse = cyc;
        n_pulses++;
      end
    end
  end

  task automatic duty(input int start, output int lo, output int hi);
    lo = 0;
    hi = 0;
    while (cyc < start) @(negedge clk);
    repeat (10) begin
      lo += int'(led[0]);
      hi += int'(led[7]);
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int seq[11] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
    int lo, hi, seen7, pulses_before;

    repeat (4) @(negedge clk);
    #1 rst = 1'b0;

    // Split-breathe: tick k lands at cycle 20k, its level shows on pins over cycles 20k+11..20k+20.
    for (int k = 1; k <= 11; k++) begin
      duty(20 * k + 11, lo, hi);
      check_eq($sformatf("split duty low k=%0d", k), 32'(lo), 32'(2 * seq[k-1]));
      check_eq($sformatf("split duty high k=%0d", k), 32'(hi), 32'(10 - 2 * seq[k-1]));
    end

    // Mode 1 -> 2 while lvl=3: pins blank until the PWM period restarts.
    while (cyc < 265) @(negedge clk);
    #1 mode = 2'd2;
    skip_gap = 1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check_eq("blank after mode change", 32'(led), 32'd0);
    end

    seen7 = 0;
    repeat (1200) begin
      @(negedge clk);
      if (led[7]) seen7 = 1;
    end
    check_eq("flow reaches led7", 32'(seen7), 32'd1);

    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    check_eq("rst mid-flow led", 32'(led), 32'd0);

    repeat (30) @(negedge clk);
    #1 speed = 2'd3;
    skip_gap = 1;
    exp_gap = 80;
    pulses_before = n_pulses;
    repeat (400) @(negedge clk);
    check_eq("speed3 pulse count", 32'(n_pulses - pulses_before), 32'd5);

    #1 speed = 2'd0;
    skip_gap = 1;
    exp_gap = 20;
    repeat (200) @(negedge clk);

    #1 mode = 2'd0;
    pulses_before = n_pulses;
    repeat (300) @(negedge clk);
    check_eq("off pulse count", 32'(n_pulses - pulses_before), 32'd0);
    check_eq("off led", 32'(led), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
